// File: rtl/mips_ifetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a
// req/ack port, and presents it downstream with a valid/ready handshake.
module mips_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ack,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch,
  input  logic             jump,
  input  logic             zero,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {S_REQ, S_VALID} state_t;

  state_t           state_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      instr_reg;
  logic [CNT_W-1:0] retired_reg;

  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jt_target;
  logic [31:0] pc_next;

  assign pc_plus4  = pc_reg + 32'd4;
  assign br_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  assign br_target = pc_plus4 + br_offset;
  assign jt_target = {pc_plus4[31:28], instr_reg[25:0], 2'b00};

  // Jump outranks a taken branch; a branch with zero=0 falls through.
  always_comb begin
    pc_next = pc_plus4;
    if (jump)
      pc_next = jt_target;
    else if (branch && zero)
      pc_next = br_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_REQ;
      pc_reg      <= {RESET_PC[31:2], 2'b00};
      instr_reg   <= 32'd0;
      retired_reg <= '0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imem_ack) begin
            instr_reg <= imem_rdata;
            state_reg <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            pc_reg      <= pc_next;
            retired_reg <= retired_reg + CNT_W'(1);
            state_reg   <= S_REQ;
          end
        end
        default: state_reg <= S_REQ;
      endcase
    end
  end

  assign imem_req    = (state_reg == S_REQ);
  assign instr_valid = (state_reg == S_VALID);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign op          = instr_reg[31:26];
  assign retired     = retired_reg;

endmodule

// File: doc/mips_ifetch.md
Name: mips_ifetch

Overview:
- Instruction-fetch stage of the MIPS processor; feeds the opcode decoder and the datapath.
- Holds the PC and fetches one word per instruction over a req/ack instruction-memory port.
- Presents the instruction with a valid/ready handshake and computes the next PC from the decoder's Branch/Jump outputs and the ALU zero flag.
- One instruction in flight; no prefetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  byte address of the fetch, equals pc
- imem_rdata  in  32  instruction word, sampled when imem_ack=1
- imem_ack  in  1  memory has returned imem_rdata this cycle
- instr  out  32  held instruction word
- op  out  6  instr[31:26], to the opcode decoder
- instr_valid  out  1  instr/op/pc are valid for downstream
- instr_ready  in  1  downstream consumes the instruction this cycle
- branch  in  1  decoder Branch for the current instr; sampled only on the accept cycle
- jump  in  1  decoder Jump; sampled only on the accept cycle
- zero  in  1  ALU zero flag; sampled only on the accept cycle
- pc  out  32  address of the current instruction
- pc_plus4  out  32  pc+4, combinational
- retired  out  CNT_W  count of accepted instructions

Behaviour:
- Reset (synchronous, active-high):
  - pc<=RESET_PC, instr<=0, state<=S_REQ, retired<=0.
  - Reset dominates every other input in the same cycle.
  - A reset mid-fetch abandons the request; a late imem_ack is ignored only if it arrives in the reset cycle.
  - Next cycle is a fresh S_REQ at RESET_PC.
- State machine, 2 states:
  - S_REQ:
    - imem_req=1, imem_addr=pc, instr_valid=0.
    - If imem_ack=1: instr<=imem_rdata, go to S_VALID.
    - Otherwise stay; pc and imem_addr held stable.
  - S_VALID:
    - imem_req=0, instr_valid=1.
    - If instr_ready=1: pc<=next_pc, retired<=retired+1 (wraps modulo 2^CNT_W), go to S_REQ.
    - Otherwise hold all state.
- imem_ack while imem_req=0 is ignored.
- instr_ready while instr_valid=0 is ignored; no counter or pc change.
- Next-PC (combinational, used only on the accept cycle):
  - seq = pc_plus4 = pc+4, modulo 2^32 (wrap from 32'hFFFF_FFFC gives 0).
  - br = pc_plus4 + ({{14{instr[15]}},instr[15:0],2'b00}), 32-bit wrap.
  - jt = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Priority: jump=1 selects jt; else branch=1 and zero=1 selects br; else seq.
  - branch=1 with zero=0 selects seq.
- pc[1:0] is always 0.
- Latency:
  - Reset deasserted at edge N: imem_req=1 in cycle N.
  - With ack in the same cycle, instr_valid=1 in cycle N+1.
  - Minimum 2 cycles per instruction.
- Output registers: instr, pc, retired and state are registered; op, pc_plus4, imem_addr, imem_req and instr_valid decode from them.

Test Plan:
- Reset, then zero-wait memory returning 32'h2008_0005 (addi) at 32'h3000:
  - imem_req high cycle 0, instr_valid cycle 1, op=6'b001000.
  - instr_ready=1 with branch=0, jump=0 gives the next imem_addr=32'h3004 and retired=1.
- imem_ack delayed 3 cycles:
  - imem_addr stays 32'h3000 and instr_valid stays 0 throughout.
  - instr_valid asserts the cycle after ack.
  - instr_ready held low 4 cycles keeps pc and instr stable and retired unchanged.
- beq 32'h1000_FFFF at pc=32'h3010, branch=1:
  - zero=1 gives next pc=32'h3010.
  - Repeating with zero=0 gives 32'h3014.
  - Offset 16'h0004 with zero=1 gives 32'h3024.
- j 32'h0800_0C00 at pc=32'h3000 with jump=1 and branch=1 simultaneously gives next pc=32'h0000_3000; jump wins.
- Reset asserted in S_VALID and in S_REQ with imem_ack=1 in the same cycle:
  - instr_valid=0 and pc=32'h3000 the next cycle.
  - instr is not updated and retired=0.
- Wrap boundaries:
  - pc=32'hFFFF_FFFC with sequential advance gives next pc=0.
  - retired forced to all-ones (CNT_W=4 build, value 15) then one accept gives 0.
  - Spurious imem_ack in S_VALID and instr_ready in S_REQ cause no state change.
